// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decode handshake and PC redirect.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  // Fetch unit side.
  modport master (
    output mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
    input  mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  // Memory / decode side.
  modport slave (
    input  mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
    output mem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads four bytes (big-endian, lowest address in MSB) from a byte-wide
// synchronous memory, presents the word to decode, and halts on an all-zero instruction.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                halted,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StFetch, StLast, StHold, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       bytes_q, bytes_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [31:0]       word;
  logic              unused_redirect_lsb;

  assign redirect_tgt        = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  // Byte 3 arrives on the bus during LAST, so the word is completed combinationally.
  assign word                = {bytes_q, bus.mem_rdata};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      bytes_q    <= 24'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      bytes_q    <= bytes_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next-state logic; a redirect overrides everything except HALT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    bytes_d    = bytes_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    if (bus.redirect_valid && (state_q != StHalt)) begin
      pc_d    = redirect_tgt;
      cnt_d   = 2'd0;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            cnt_d   = 2'd0;
            state_d = StFetch;
          end
        end
        StFetch: begin
          // Data for address pc+k-1 is on mem_rdata during cycle k.
          case (cnt_q)
            2'd1:    bytes_d[23:16] = bus.mem_rdata;
            2'd2:    bytes_d[15:8]  = bus.mem_rdata;
            2'd3:    bytes_d[7:0]   = bus.mem_rdata;
            default: ;
          endcase
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = StLast;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        StLast: begin
          if (word == 32'd0) begin
            state_d = StHalt;
          end else begin
            instr_d    = word;
            instr_pc_d = pc_q;
            state_d    = StHold;
          end
        end
        StHold: begin
          if (bus.instr_ready) begin
            pc_d    = pc_q + ADDR_W'(4);
            cnt_d   = 2'd0;
            state_d = StFetch;
          end
        end
        StHalt: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state so reset clears them immediately.
  always_comb begin
    bus.mem_addr    = pc_q + ADDR_W'(cnt_q);
    bus.mem_rd_en   = (state_q == StFetch);
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.instr_valid = (state_q == StHold);
    halted          = (state_q == StHalt);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a randomized
// run checked against a PC/instruction reference model.
module tb_instr_fetch_unit;
  localparam int unsigned AW = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic halted;

  instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

  instr_fetch_unit #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .halted (halted),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [128];

  // Synchronous-read instruction memory, one cycle latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    logic [AW-1:0] a1, a2, a3;
    a1 = a + 7'd1;
    a2 = a + 7'd2;
    a3 = a + 7'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int cycles;
    cycles = 0;
    while (!bus.instr_valid && cycles < limit) begin
      step();
      cycles++;
    end
    chk(tag, {31'd0, bus.instr_valid}, 32'd1);
  endtask

  // Random contents, every aligned word forced non-zero.
  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 128; i += 4) mem[i][0] = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, {31'd0, bus.mem_rd_en}, 32'd0);
    chk({tag, "_addr"}, {25'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_instr_pc"}, {25'd0, bus.instr_pc}, 32'd0);
  endtask

  initial begin
    logic          saw_valid;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] rpc;
    logic          rv, rdy, vld;
    int            accepted;

    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    fill_mem();
    {mem[0], mem[1], mem[2], mem[3]}  = 32'h002081B3;
    {mem[4], mem[5], mem[6], mem[7]}  = 32'h402081B3;
    {mem[8], mem[9], mem[10], mem[11]} = 32'h0;

    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("idle_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    chk("idle_valid", {31'd0, bus.instr_valid}, 32'd0);

    // Basic fetch with 5-cycle latency and 6-cycle throughput.
    en = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    en = 1'b0;
    chk("fetch_entry_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("fetch_entry_addr", {25'd0, bus.mem_addr}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("latency_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    step();
    chk("first_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("first_instr", bus.instr, 32'h002081B3);
    chk("first_pc", {25'd0, bus.instr_pc}, 32'd0);
    step();
    bus.instr_ready = 1'b0;
    chk("after_accept_valid", {31'd0, bus.instr_valid}, 32'd0);
    for (int i = 2; i < 6; i++) begin
      step();
      chk("thruput_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    step();
    chk("second_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("second_instr", bus.instr, 32'h402081B3);
    chk("second_pc", {25'd0, bus.instr_pc}, 32'd4);

    // Backpressure: hold stable, no memory reads.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("bp_instr", bus.instr, 32'h402081B3);
      chk("bp_pc", {25'd0, bus.instr_pc}, 32'd4);
      chk("bp_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    end

    // Redirect and ready together: redirect wins.
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'd40;
    step();
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("collide_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    chk("collide_addr", {25'd0, bus.mem_addr}, 32'd40);
    wait_valid("collide_wait", 20);
    chk("collide_pc", {25'd0, bus.instr_pc}, 32'd40);
    chk("collide_instr", bus.instr, word_at(7'd40));

    // Accept after stall: pc advances by exactly 4.
    step();
    step();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("adv_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    wait_valid("adv_wait", 20);
    chk("adv_pc", {25'd0, bus.instr_pc}, 32'd44);

    // Zero halt at pc=8 after consuming 0 and 4.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'd0;
    step();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    wait_valid("halt_w0", 20);
    chk("halt_pc0", {25'd0, bus.instr_pc}, 32'd0);
    step();
    wait_valid("halt_w4", 20);
    chk("halt_pc4", {25'd0, bus.instr_pc}, 32'd4);
    saw_valid = 1'b0;
    for (int i = 0; i < 20 && !halted; i++) begin
      step();
      if (bus.instr_valid) saw_valid = 1'b1;
    end
    chk("halted_set", {31'd0, halted}, 32'd1);
    chk("halt_no_valid", {31'd0, saw_valid}, 32'd0);
    en                 = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_sticky", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("halt_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    end
    en                 = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("halt_cleared", {31'd0, halted}, 32'd0);

    // Redirect during FETCH k=2 drops partial bytes.
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    step();
    chk("mid_k2_addr", {25'd0, bus.mem_addr}, 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'd22;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_seq_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
      chk("mid_seq_addr", {25'd0, bus.mem_addr}, 32'(20 + i));
      step();
    end
    wait_valid("mid_wait", 20);
    chk("mid_pc", {25'd0, bus.instr_pc}, 32'd20);
    chk("mid_instr", bus.instr, word_at(7'd20));

    // Wrap from 124 to 0.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'd124;
    step();
    bus.redirect_valid = 1'b0;
    wait_valid("wrap_w124", 20);
    chk("wrap_pc124", {25'd0, bus.instr_pc}, 32'd124);
    chk("wrap_instr124", bus.instr, word_at(7'd124));
    bus.instr_ready = 1'b1;
    step();
    wait_valid("wrap_w0", 20);
    chk("wrap_pc0", {25'd0, bus.instr_pc}, 32'd0);
    chk("wrap_instr0", bus.instr, 32'h002081B3);

    // Asynchronous reset in the middle of FETCH.
    step();
    step();
    chk("pre_rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    bus.instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the PC/instruction model.
    fill_mem();
    exp_pc             = 7'($urandom) & 7'h7C;
    bus.redirect_pc    = exp_pc | 7'($urandom_range(0, 3));
    bus.redirect_valid = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    accepted = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      vld = bus.instr_valid;
      if (vld) begin
        chk("rand_pc", {25'd0, bus.instr_pc}, {25'd0, exp_pc});
        chk("rand_instr", bus.instr, word_at(exp_pc));
      end
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = 7'($urandom);
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.instr_ready    = rdy;
      if (rv) begin
        exp_pc = {rpc[AW-1:2], 2'b00};
      end else if (vld && rdy) begin
        exp_pc = exp_pc + 7'd4;
        accepted++;
      end
      step();
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    chk("rand_progress", {31'd0, (accepted >= 10)}, 32'd1);
    chk("rand_not_halted", {31'd0, halted}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
